// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a 16x8 single-port RAM: IDLE -> ACCESS -> DONE per access,
// simultaneous requests alternate between ports, every output comes from a register.
module ram_arbiter #(
    parameter int FIRST_PRIO = 0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [3:0] addr0,
    input  logic [3:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    input  logic [7:0] ram_rdata,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic       busy,
    output logic [3:0] ram_address,
    output logic [7:0] ram_dataIn,
    output logic       ram_writeEnable,
    output logic [1:0] dbg_state
);
    // Handshake: a port raises req with we/addr/wdata stable and holds it until its
    // one-cycle ack; the request is only sampled in IDLE, so late changes are ignored.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Seeding last_grant with the other port makes FIRST_PRIO win the first tie.
    localparam logic LAST_GRANT_RST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

    state_t     r_state;
    logic       r_winner;
    logic       r_last_grant;
    logic       r_ack0;
    logic       r_ack1;
    logic       r_we;
    logic [3:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    logic       w_win;

    assign w_win = (req0 && req1) ? ~r_last_grant : req1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_winner     <= 1'b0;
            r_last_grant <= LAST_GRANT_RST;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= 4'd0;
            r_wdata      <= 8'd0;
            r_rdata      <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r_winner     <= w_win;
                        r_last_grant <= w_win;
                        r_we         <= w_win ? we1 : we0;
                        r_addr       <= w_win ? addr1 : addr0;
                        r_wdata      <= w_win ? wdata1 : wdata0;
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // The RAM commits the write on this same edge, so the strobe drops here.
                    if (!r_we) begin
                        r_rdata <= ram_rdata;
                    end
                    r_we    <= 1'b0;
                    r_ack0  <= ~r_winner;
                    r_ack1  <= r_winner;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_we    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack0            = r_ack0;
    assign ack1            = r_ack1;
    assign rdata           = r_rdata;
    assign busy            = (r_state != S_IDLE);
    assign ram_address     = r_addr;
    assign ram_dataIn      = r_wdata;
    assign ram_writeEnable = r_we;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 16x8 RAM; a negedge monitor pops
// the expected {port, rdata} of every ack from a scoreboard queue.
module tb_ram_arbiter;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [3:0] addr0 = 4'd0, addr1 = 4'd0;
    logic [7:0] wdata0 = 8'd0, wdata1 = 8'd0;
    logic       ack0, ack1, busy, ram_writeEnable;
    logic [7:0] rdata, ram_dataIn, ram_rdata;
    logic [3:0] ram_address;
    logic [1:0] dbg_state;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] exp_q[$];

    logic [7:0] mem [16];
    logic       init_done = 1'b0;

    ram_arbiter #(.FIRST_PRIO(0)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ram_rdata(ram_rdata),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .ram_address(ram_address), .ram_dataIn(ram_dataIn),
        .ram_writeEnable(ram_writeEnable), .dbg_state(dbg_state)
    );

    // clock / reset-free RAM model: mem[i] starts at i*0x11
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!init_done) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(i * 17);
            init_done <= 1'b1;
        end else if (ram_writeEnable) begin
            mem[ram_address] <= ram_dataIn;
        end
    end

    assign ram_rdata = mem[ram_address];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endfunction

    // monitor / scoreboard
    always @(negedge clock) begin : monitor
        logic [8:0] e;
        if (reset_n && (ack0 || ack1)) begin
            check("ack_exclusive", 32'(ack0 & ack1), 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b rdata=%0h, required no ack", ack0, ack1, rdata);
            end else begin
                e = exp_q.pop_front();
                check("ack_port", 32'(ack1), 32'(e[8]));
                check("ack_rdata", 32'(rdata), 32'(e[7:0]));
            end
        end
        if (ram_writeEnable) check("we_only_in_access", 32'(dbg_state), 32'd1);
    end

    // driver tasks
    task automatic check_reset_outputs();
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_ack1", 32'(ack1), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(ram_address), 32'd0);
        check("rst_dataIn", 32'(ram_dataIn), 32'd0);
        check("rst_we", 32'(ram_writeEnable), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic single_access(input logic port, input logic we, input logic [3:0] addr,
                                 input logic [7:0] wdata, input logic [7:0] exp_rd, input logic perturb);
        @(negedge clock);
        if (port) begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        end
        exp_q.push_back({port, exp_rd});
        @(posedge clock); #1;
        check("grant_we", 32'(ram_writeEnable), 32'(we));
        check("grant_addr", 32'(ram_address), 32'(addr));
        if (we) check("grant_wdata", 32'(ram_dataIn), 32'(wdata));
        check("busy_access", 32'(busy), 32'd1);
        if (perturb) begin
            addr0 = ~addr;
            wdata0 = ~wdata;
        end
        @(posedge clock); #1;
        check("we_cleared", 32'(ram_writeEnable), 32'd0);
        check("ack_winner", 32'(port ? ack1 : ack0), 32'd1);
        check("ack_other", 32'(port ? ack0 : ack1), 32'd0);
        @(posedge clock); #1;
        req0 = 1'b0;
        req1 = 1'b0;
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int n0, n1, nack, last;
        logic drop0, drop1;

        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs();
        @(negedge clock);
        reset_n = 1'b1;

        // port 0 write, port 1 read back
        single_access(1'b0, 1'b1, 4'd3, 8'hA5, 8'h00, 1'b0);
        check("mem3_written", 32'(mem[3]), 32'hA5);
        single_access(1'b1, 1'b0, 4'd3, 8'h00, 8'hA5, 1'b0);

        // address/data changed during ACCESS must not reach the RAM
        single_access(1'b0, 1'b1, 4'd5, 8'h5A, 8'hA5, 1'b1);
        single_access(1'b1, 1'b0, 4'd5, 8'h00, 8'h5A, 1'b0);
        single_access(1'b1, 1'b0, 4'd10, 8'h00, 8'hAA, 1'b0);

        // port 1 back-to-back reads of addr 15
        @(negedge clock);
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd15;
        repeat (3) exp_q.push_back({1'b1, 8'hFF});
        for (int c = 0; c < 9; c++) begin
            @(posedge clock); #1;
            check("b2b_busy", 32'(busy), 32'((c % 3) != 2));
            if ((c % 3) == 1) check("b2b_ack1", 32'(ack1), 32'd1);
        end
        req1 = 1'b0;

        // simultaneous requests after reset: 0,1,0,1 spaced 3 cycles
        do_reset();
        @(negedge clock);
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd15;
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b1, 8'hFF});
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b1, 8'hFF});
        @(posedge clock); #1;
        check("first_prio_addr", 32'(ram_address), 32'd3);
        n0 = 0; n1 = 0; nack = 0; last = -1; drop0 = 1'b0; drop1 = 1'b0;
        for (int c = 1; c < 15; c++) begin
            @(posedge clock); #1;
            if (drop0) req0 = 1'b0;
            if (drop1) req1 = 1'b0;
            if (ack0) begin n0++; if (n0 == 2) drop0 = 1'b1; end
            if (ack1) begin n1++; if (n1 == 2) drop1 = 1'b1; end
            if (ack0 || ack1) begin
                if (last >= 0) check("ack_spacing", 32'(c - last), 32'd3);
                last = c;
                nack++;
            end
        end
        check("sim_ack_count", 32'(nack), 32'd4);
        req0 = 1'b0;
        req1 = 1'b0;

        // reset during ACCESS of a write aborts it
        @(negedge clock);
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd7; wdata0 = 8'h3C;
        @(posedge clock); #1;
        check("abort_we_before", 32'(ram_writeEnable), 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clock); #1;
        check("abort_mem7", 32'(mem[7]), 32'h77);
        check("abort_no_ack", 32'(ack0 | ack1), 32'd0);
        @(negedge clock);
        req0 = 1'b0;
        reset_n = 1'b1;
        single_access(1'b1, 1'b0, 4'd7, 8'h00, 8'h77, 1'b0);

        repeat (3) @(posedge clock);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
